if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter XLEN, default 64, address/PC width.
REQ-002 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  XLEN  fetch address (PC of request).
REQ-008 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect request.
REQ-011 redirect_pc  input  XLEN  redirect target.
REQ-012 if_valid  output  1  instruction available to decode/control.
REQ-013 if_ready  input  1  decode/control consumes instruction.
REQ-014 if_pc  output  XLEN  PC of presented instruction.
REQ-015 if_instr  output  32  presented instruction word.
REQ-016 if_op_code  output  7  if_instr[6:0], feeds control op_code.
REQ-017 if_illegal  output  1  high when if_valid and if_instr[1:0] != 2'b11.

Function
REQ-018 FSM states IDLE, FETCH, WAIT, HOLD, DRAIN; at most one outstanding memory request.
REQ-019 IDLE -> FETCH unconditionally on first clock edge after rst_n deasserts.
REQ-020 FETCH: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT, else remain.
REQ-021 WAIT: on imem_rsp_valid capture data into if_instr, pc into if_pc, pc <= pc+4, -> HOLD.
REQ-022 HOLD: if_valid=1, if_instr/if_pc stable; on if_ready -> FETCH; otherwise hold indefinitely.
REQ-023 imem_req_valid only in FETCH; if_valid only in HOLD; both driven from registered state.
REQ-024 pc+4 wraps modulo 2^XLEN (all-ones-minus-3 -> 0), no flag.
REQ-025 redirect_valid has priority over every other event in the same cycle; pc <= {redirect_pc[XLEN-1:2],2'b00}.
REQ-026 Redirect in FETCH without request handshake, in HOLD, or in IDLE: next state FETCH, if_valid drops next cycle.
REQ-027 Redirect in FETCH with imem_req_ready same cycle: request is outstanding, next state DRAIN.
REQ-028 Redirect in WAIT without imem_rsp_valid: next state DRAIN; with imem_rsp_valid same cycle: response discarded, next state FETCH.
REQ-029 DRAIN: imem_rsp_valid discarded (no capture, no pc change), -> FETCH; redirect in DRAIN updates pc, stays DRAIN unless response arrives same cycle (then FETCH).
REQ-030 Redirect in HOLD coincident with if_ready: handshake counts as consumed downstream; block behaves per REQ-026.
REQ-031 imem_rsp_valid outside WAIT/DRAIN is ignored.
REQ-032 Latency: request accept to if_valid = memory latency + 1 cycle; if_ready to next imem_req_valid = 1 cycle.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, pc RESET_PC, imem_req_valid 0, imem_req_addr RESET_PC, if_valid 0, if_pc RESET_PC, if_instr 0, if_illegal 0.
REQ-034 Reset mid-transaction abandons any outstanding request; a late response after reset arrives outside WAIT and is ignored per REQ-031.

Structure
REQ-035 Shared package if_pkg holds state enum, INSTR_W=32, OPCODE_W=7, NOP=32'h00000013.
REQ-036 One sub-module pc_adder (XLEN-bit, +4, wrap) computes next sequential PC.

Verification
REQ-037 Reset, 1-cycle memory, if_ready=1: fetch addrs 0x0,0x4,0x8 -> if_op_code 7'b0110011 for word 0x003100B3 at if_pc 0x0.
REQ-038 if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc, if_instr unchanged, imem_req_valid 0 throughout.
REQ-039 Redirect to 0x103 while WAIT, response arrives next cycle -> response dropped, next request addr 0x100.
REQ-040 Redirect coincident with imem_rsp_valid in WAIT -> no if_valid, next request addr = redirect target.
REQ-041 pc=64'hFFFF_FFFF_FFFF_FFFC fetch completes -> next request addr 0x0.
REQ-042 rst_n pulsed low during WAIT, response delivered during reset -> outputs at reset values, first request addr RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// instruction field widths and the canonical NOP word.
package if_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 7;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } if_state_t;

endpackage

// File: rtl/pc_adder.sv
// Next sequential PC: pc + 4, wrapping silently modulo 2^XLEN.
module pc_adder #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    assign pc_plus4 = pc + XLEN'(4);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one request at a time to instruction
// memory, holds the returned word for decode, and handles redirects.
// A redirect that leaves a request in flight goes through DRAIN so the
// stale response is swallowed before the next fetch is issued.
module if_stage
    import if_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_pc,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [OPCODE_W-1:0] if_op_code,
    output logic                if_illegal
);

    if_state_t          state;
    if_state_t          state_next;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_next;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    redirect_aligned;
    logic               capture;

    pc_adder #(.XLEN(XLEN)) u_pc_adder (
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;
    assign if_valid       = (state == HOLD);
    assign if_op_code     = if_instr[OPCODE_W-1:0];
    assign if_illegal     = if_valid && (if_instr[1:0] != 2'b11);

    // Next-state, next-PC and capture decision; redirect outranks everything.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                state_next = FETCH;
                if (redirect_valid) pc_next = redirect_aligned;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = imem_req_ready ? DRAIN : FETCH;
                end else if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = imem_rsp_valid ? FETCH : DRAIN;
                end else if (imem_rsp_valid) begin
                    capture    = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = FETCH;
                end else if (if_ready) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) pc_next = redirect_aligned;
                if (imem_rsp_valid) state_next = FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, PC and presented-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_pc    <= RESET_PC;
            if_instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture) begin
                if_instr <= imem_rsp_data;
                if_pc    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: walks the fetch FSM cycle by cycle with
// hand-computed expected addresses, PCs and instruction words.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_op_code;
    logic        if_illegal;

    int checks = 0;
    int errors = 0;

    if_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_op_code     (if_op_code),
        .if_illegal     (if_illegal)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_req_valid"}, imem_req_valid, 0);
        checkOutput({tag, "_req_addr"}, imem_req_addr, 64'h0);
        checkOutput({tag, "_if_valid"}, if_valid, 0);
        checkOutput({tag, "_if_pc"}, if_pc, 64'h0);
        checkOutput({tag, "_if_instr"}, if_instr, 0);
        checkOutput({tag, "_if_illegal"}, if_illegal, 0);
    endtask

    // One complete fetch starting in FETCH; 1-cycle memory latency,
    // optional stall in HOLD with a stray response that must be ignored.
    task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] word, input int hold_cycles);
        checkOutput("fetch_req_valid", imem_req_valid, 1);
        checkOutput("fetch_req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checkOutput("wait_req_valid", imem_req_valid, 0);
        checkOutput("wait_if_valid", if_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        step();
        imem_rsp_valid = 1'b0;
        checkOutput("hold_if_valid", if_valid, 1);
        checkOutput("hold_if_pc", if_pc, addr);
        checkOutput("hold_if_instr", {32'h0, if_instr}, {32'h0, word});
        checkOutput("hold_op_code", {57'h0, if_op_code}, {57'h0, word[6:0]});
        checkOutput("hold_illegal", if_illegal, (word[1:0] != 2'b11));
        for (int i = 0; i < hold_cycles; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            step();
            imem_rsp_valid = 1'b0;
            checkOutput("stall_if_valid", if_valid, 1);
            checkOutput("stall_if_pc", if_pc, addr);
            checkOutput("stall_if_instr", {32'h0, if_instr}, {32'h0, word});
            checkOutput("stall_req_valid", imem_req_valid, 0);
        end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        checkOutput("after_if_valid", if_valid, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;

        $display("[TB] reset and sequential fetch");
        repeat (2) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        applyStimulus(64'h0, 32'h0031_00B3, 0);
        checkOutput("opcode_r_type", 7'b0110011, 7'h33);
        applyStimulus(64'h4, 32'h0000_0013, 0);
        applyStimulus(64'h8, 32'h0000_0012, 0);

        $display("[TB] stall in HOLD");
        applyStimulus(64'hC, 32'h0040_0093, 5);

        $display("[TB] redirect during WAIT, late response dropped");
        checkOutput("r39_req_addr", imem_req_addr, 64'h10);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        step();
        redirect_valid = 1'b0;
        checkOutput("r39_drain_req_valid", imem_req_valid, 0);
        checkOutput("r39_drain_if_valid", if_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        step();
        imem_rsp_valid = 1'b0;
        checkOutput("r39_if_valid", if_valid, 0);
        checkOutput("r39_if_pc", if_pc, 64'hC);
        applyStimulus(64'h100, 32'h0000_0033, 0);

        $display("[TB] redirect coincident with response in WAIT");
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2223;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        checkOutput("r40_if_valid", if_valid, 0);
        checkOutput("r40_req_valid", imem_req_valid, 1);
        checkOutput("r40_req_addr", imem_req_addr, 64'h200);
        checkOutput("r40_if_instr", {32'h0, if_instr}, 64'h0000_0033);

        $display("[TB] redirect in HOLD with if_ready, redirect on accepted request");
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0073;
        step();
        imem_rsp_valid = 1'b0;
        checkOutput("r30_if_valid", if_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        checkOutput("r30_if_valid_drop", if_valid, 0);
        checkOutput("r30_req_addr", imem_req_addr, 64'h40);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        checkOutput("r27_drain_req_valid", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        checkOutput("r27_req_valid", imem_req_valid, 1);
        checkOutput("r27_req_addr", imem_req_addr, 64'h80);
        checkOutput("r27_if_valid", if_valid, 0);

        $display("[TB] PC wrap");
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 0);
        checkOutput("wrap_req_addr", imem_req_addr, 64'h0);

        $display("[TB] reset during WAIT");
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_3333;
        step();
        imem_rsp_valid = 1'b0;
        check_reset_outputs("in_rst");
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_req_valid", imem_req_valid, 1);
        checkOutput("post_rst_req_addr", imem_req_addr, 64'h0);
        checkOutput("post_rst_if_valid", if_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
